sobel_window_ctrl: RTL
======================

// Module: sobel_window_ctrl
// PURPOSE
//  Streams camera grey pixels (raster order, one per accepted beat) into two line buffers and
//  a 3x3 window register, and drives the combinational sobel_conv datapath with it.
//  Emits one registered edge-magnitude pixel per accepted input pixel, with frame and line flags.
//  Sits between the D8M grey-conversion stage and the VGA frame-buffer writer.
// PARAMETERS
//  IMG_W   640  active pixels per line (>=4)
//  IMG_H   480  active lines per frame (>=3)
//  PIX_W   8    pixel width; must match sobel_conv (8)
// PORTS
//  clk         in   1      single system clock; all logic on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  en          in   1      1 = Sobel output, 0 = pass-through of in_pix (sampled per beat)
//  in_valid    in   1      input pixel beat; no backpressure, gaps allowed
//  in_sof      in   1      qualifies in_valid: this beat is pixel (0,0) of a frame
//  in_pix      in   PIX_W  grey pixel
//  out_valid   out  1      output beat, exactly 1 cycle after each accepted input
//  out_sof     out  1      with out_valid: output for input (0,0)
//  out_eol     out  1      with out_valid: output for input x==IMG_W-1
//  out_pix     out  PIX_W  edge magnitude (saturated 0..255) or pass-through pixel
//  frame_done  out  1      1-cycle pulse with out_valid for input (IMG_W-1,IMG_H-1)
// BEHAVIOUR
//  - Reset: out_valid/out_sof/out_eol/frame_done=0, out_pix=0, x=y=0, window regs=0.
//    Line-buffer RAM is not cleared; row masking below hides stale contents.
//  - Counters x in [0,IMG_W-1] and y in [0,IMG_H-1] advance only on in_valid.
//    x wraps to 0 and increments y. y wraps to 0 after (IMG_W-1,IMG_H-1).
//  - in_sof=1 on a beat forces that pixel to (0,0), even mid-frame. Counters restart.
//    Line buffers are kept, but rows y<2 are masked.
//  - Per accepted beat at (x,y):
//    - read lb0[x] (row y-1) and lb1[x] (row y-2), read-before-write;
//    - write lb1[x]<=lb0[x] and lb0[x]<=in_pix;
//    - shift window columns left; new right column = {lb1[x], lb0[x], in_pix}.
//  - Window mapping to sobel_conv (columns x-2..x):
//    - pixel0..2 = row y-2;
//    - pixel3..5 = row y-1;
//    - pixel6..8 = row y.
//  - Result is centred at (x-1,y-1) and registered to out_pix. Latency is 1 clock.
//    The image is shifted by one pixel right and one line down, by design.
//  - Masking: if x<2 or y<2, out_pix=0 when en=1. No left-edge wrap data leaks into the output.
//  - en=0: out_pix = in_pix of the same beat. Flags and counters are unchanged.
//  - No in_valid: out_valid=0, out_pix holds its last value, window holds.
//  - Magnitude: sqrt(gx^2+gy^2), floor integer root, saturated to 0xFF. Bit-exact to sobel_conv.
//  - Reset asserted mid-frame aborts immediately. The next frame must start with in_sof.
// STRUCTURE
//  - Shared package sobel_pkg holds the following, shared with the frame-buffer writer:
//    - IMG_W/IMG_H defaults and PIX_W;
//    - X_W=$clog2(IMG_W) and Y_W=$clog2(IMG_H);
//    - window typedef win3x3_t (9 x PIX_W).
//  - Sub-module sobel_line_buf: 2 x IMG_W x PIX_W rows, one addr, read-before-write.
//    A registered-read RAM plus prefetch is allowed if the port-level timing above holds.
//  - sobel_conv is instantiated unchanged as the datapath.
//  - The controller holds counters, window regs, masking and the output register.
// TESTING (bench IMG_W=8, IMG_H=6, golden model = floor-sqrt Sobel with 0xFF saturation)
//  1 Uniform 0x80 frame, in_valid every cycle.
//    -> 48 outputs, all 0x00; out_sof on the first, out_eol every 8th, frame_done on the 48th.
//  2 Vertical edge: cols 0-3=0x00, cols 4-7=0xFF, en=1.
//    -> out_pix=0xFF at x in {4,5}, y>=2; 0x00 elsewhere.
//  3 Same frame as 2 with in_valid toggled 1,0,0,1,...
//    -> identical output sequence; out_valid only the cycle after each beat.
//  4 Random frame with in_sof re-asserted at pixel 20.
//    -> outputs restart at (0,0); masking applies to the new rows 0-1.
//    -> Later pixels match golden from pixel 20 onward.
//  5 en=0, pixels 0x01..0x30.
//    -> out_pix equals each input 1 cycle later; flags as in 1.
//  6 rst_n=0 for 1 cycle at pixel 30, then a full frame with in_sof.
//    -> out_valid=0 during reset; the new frame matches golden; no frame_done for the aborted frame.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared Sobel constants, window type and integer square root, common to the
// window controller and the frame-buffer writer.
package sobel_pkg;

  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int PIX_W = 8;
  localparam int X_W   = $clog2(IMG_W);
  localparam int Y_W   = $clog2(IMG_H);

  // Index k holds row k/3 (0 = oldest line) and column k%3 (0 = leftmost).
  typedef logic [8:0][PIX_W-1:0] win3x3_t;

  // Floor square root of a 21-bit value, one result bit per step (MSB first).
  function automatic logic [10:0] isqrt21(input logic [20:0] v);
    logic [10:0] root;
    logic [10:0] trial;
    logic [21:0] trial_sq;
    root = '0;
    for (int i = 10; i >= 0; i--) begin
      trial    = root | (11'd1 << i);
      trial_sq = {11'd0, trial} * {11'd0, trial};
      if (trial_sq <= {1'b0, v}) root = trial;
    end
    return root;
  endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel stream bundle between the grey-conversion source and the Sobel controller.
interface sobel_window_ctrl_if #(
  parameter int PIX_W = sobel_pkg::PIX_W
);

  logic             en;
  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pix;
  logic             out_valid;
  logic             out_sof;
  logic             out_eol;
  logic [PIX_W-1:0] out_pix;
  logic             frame_done;

  modport master (
    output en, in_valid, in_sof, in_pix,
    input  out_valid, out_sof, out_eol, out_pix, frame_done
  );

  modport slave (
    input  en, in_valid, in_sof, in_pix,
    output out_valid, out_sof, out_eol, out_pix, frame_done
  );

endinterface

// File: rtl/sobel_conv.sv
// Combinational 3x3 Sobel: floor(sqrt(gx^2 + gy^2)) saturated to 8 bits.
module sobel_conv
  import sobel_pkg::isqrt21;
(
  input  logic [7:0] pixel0,
  input  logic [7:0] pixel1,
  input  logic [7:0] pixel2,
  input  logic [7:0] pixel3,
  input  logic [7:0] pixel4,
  input  logic [7:0] pixel5,
  input  logic [7:0] pixel6,
  input  logic [7:0] pixel7,
  input  logic [7:0] pixel8,
  output logic [7:0] magnitude
);

  logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg;
  logic [9:0]  gx_abs, gy_abs;
  logic [19:0] gx_sq, gy_sq;
  logic [20:0] mag_sq;
  logic [10:0] root;

  // Positive and negative kernel halves stay unsigned; only |g| is needed.
  assign gx_pos = {2'b00, pixel2} + {1'b0, pixel5, 1'b0} + {2'b00, pixel8};
  assign gx_neg = {2'b00, pixel0} + {1'b0, pixel3, 1'b0} + {2'b00, pixel6};
  assign gy_pos = {2'b00, pixel6} + {1'b0, pixel7, 1'b0} + {2'b00, pixel8};
  assign gy_neg = {2'b00, pixel0} + {1'b0, pixel1, 1'b0} + {2'b00, pixel2};

  assign gx_abs = (gx_pos >= gx_neg) ? (gx_pos - gx_neg) : (gx_neg - gx_pos);
  assign gy_abs = (gy_pos >= gy_neg) ? (gy_pos - gy_neg) : (gy_neg - gy_pos);

  assign gx_sq  = {10'd0, gx_abs} * {10'd0, gx_abs};
  assign gy_sq  = {10'd0, gy_abs} * {10'd0, gy_abs};
  assign mag_sq = {1'b0, gx_sq} + {1'b0, gy_sq};

  assign root      = isqrt21(mag_sq);
  assign magnitude = (root > 11'd255) ? 8'hFF : root[7:0];

endmodule

// File: rtl/sobel_line_buf.sv
// Two line buffers sharing one column address: row1 = line y-1, row2 = line y-2.
// Reads are asynchronous so the current beat sees the values from before its write.
module sobel_line_buf #(
  parameter int IMG_W = sobel_pkg::IMG_W,
  parameter int PIX_W = sobel_pkg::PIX_W,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] row1,
  output logic [PIX_W-1:0] row2
);

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];

  assign row1 = lb0[addr];
  assign row2 = lb1[addr];

  // NOTE: RAM contents are deliberately not reset so the arrays map onto block/distributed RAM;
  // the controller masks rows that could still hold stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-scan controller: pixel counters, 3x3 window, edge masking and a registered
// output stage driving one edge-magnitude (or pass-through) pixel per input beat.
module sobel_window_ctrl #(
  parameter int IMG_W = sobel_pkg::IMG_W,
  parameter int IMG_H = sobel_pkg::IMG_H,
  parameter int PIX_W = sobel_pkg::PIX_W
) (
  input  logic                clk,
  input  logic                rst_n,
  sobel_window_ctrl_if.slave  bus
);

  import sobel_pkg::win3x3_t;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic             beat;
  logic [XW-1:0]    x_q, cur_x, x_nxt;
  logic [YW-1:0]    y_q, cur_y, y_nxt;
  logic             last_x, last_y, masked;
  logic [PIX_W-1:0] row1, row2;
  win3x3_t          win_q, win_nxt;
  logic [7:0]       mag;
  logic [PIX_W-1:0] pix_nxt;

  logic             valid_q, sof_q, eol_q, done_q;
  logic [PIX_W-1:0] pix_q;

  assign beat = bus.in_valid;

  // A start-of-frame beat is pixel (0,0) whatever the counters say.
  assign cur_x  = bus.in_sof ? '0 : x_q;
  assign cur_y  = bus.in_sof ? '0 : y_q;
  assign last_x = (cur_x == X_LAST);
  assign last_y = (cur_y == Y_LAST);

  always_comb begin
    x_nxt = cur_x + XW'(1);
    y_nxt = cur_y;
    if (last_x) begin
      x_nxt = '0;
      y_nxt = last_y ? '0 : cur_y + YW'(1);
    end
  end

  sobel_line_buf #(
    .IMG_W (IMG_W),
    .PIX_W (PIX_W),
    .AW    (XW)
  ) u_line_buf (
    .clk   (clk),
    .we    (beat & rst_n),
    .addr  (cur_x),
    .wdata (bus.in_pix),
    .row1  (row1),
    .row2  (row2)
  );

  // Window after this beat: columns slide left, new right column from the line buffers.
  always_comb begin
    // NOTE: assigning the whole vector first gives every bit a value on every path,
    // so no latch is inferred for the slices overwritten below.
    win_nxt = win_q;
    for (int r = 0; r < 3; r++) begin
      win_nxt[r*3]     = win_q[r*3 + 1];
      win_nxt[r*3 + 1] = win_q[r*3 + 2];
    end
    win_nxt[2] = row2;
    win_nxt[5] = row1;
    win_nxt[8] = bus.in_pix;
  end

  sobel_conv u_conv (
    .pixel0    (win_nxt[0]),
    .pixel1    (win_nxt[1]),
    .pixel2    (win_nxt[2]),
    .pixel3    (win_nxt[3]),
    .pixel4    (win_nxt[4]),
    .pixel5    (win_nxt[5]),
    .pixel6    (win_nxt[6]),
    .pixel7    (win_nxt[7]),
    .pixel8    (win_nxt[8]),
    .magnitude (mag)
  );

  // Columns x<2 still hold the previous line's tail; rows y<2 may be stale RAM.
  assign masked = (cur_x < XW'(2)) || (cur_y < YW'(2));

  always_comb begin
    pix_nxt = bus.in_pix;
    if (bus.en) pix_nxt = masked ? '0 : PIX_W'(mag);
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
      pix_q   <= '0;
    end else begin
      valid_q <= beat;
      sof_q   <= beat && (cur_x == '0) && (cur_y == '0);
      eol_q   <= beat && last_x;
      done_q  <= beat && last_x && last_y;
      if (beat) begin
        x_q   <= x_nxt;
        y_q   <= y_nxt;
        win_q <= win_nxt;
        pix_q <= pix_nxt;
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_sof    = sof_q;
  assign bus.out_eol    = eol_q;
  assign bus.out_pix    = pix_q;
  assign bus.frame_done = done_q;

endmodule
